// File: rtl/timer_counter_ar_if.sv
// Control/status bundle between the APB register block and the timer core.
// The register block drives the master side; the counting core is the slave.
interface timer_counter_ar_if #(
  parameter int WIDTH = 16,
  parameter int CKS_W = 2
);
  logic             en;
  logic             load;
  logic             updown;
  logic             arld;
  logic [CKS_W-1:0] cks;
  logic [WIDTH-1:0] tdr;
  logic [WIDTH-1:0] cmp;
  logic [2:0]       clr_flags;
  logic [2:0]       irq_en;
  logic [WIDTH-1:0] cnt;
  logic             tick;
  logic             ovf_flag;
  logic             udf_flag;
  logic             cmp_flag;
  logic             irq;

  modport master (
    output en, load, updown, arld, cks, tdr, cmp, clr_flags, irq_en,
    input  cnt, tick, ovf_flag, udf_flag, cmp_flag, irq
  );

  modport slave (
    input  en, load, updown, arld, cks, tdr, cmp, clr_flags, irq_en,
    output cnt, tick, ovf_flag, udf_flag, cmp_flag, irq
  );
endinterface

// File: rtl/timer_counter_ar.sv
// Timer counting core: power-of-two prescaler tick enable, up/down counter with
// optional auto-reload, compare match, sticky flags and a masked registered irq.
module timer_counter_ar #(
  parameter int WIDTH   = 16,
  parameter int CKS_W   = 2,
  parameter int PRESC_W = (1 << CKS_W) - 1
) (
  input  logic              pclk,
  input  logic              preset,
  timer_counter_ar_if.slave bus
);

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_mask;
  logic               tick;
  logic [WIDTH-1:0]   cnt_q;
  logic [WIDTH-1:0]   cnt_nxt;
  logic               ovf_set;
  logic               udf_set;
  logic               cmp_set;
  logic               ovf_q;
  logic               udf_q;
  logic               cmp_q;
  logic               irq_q;
  logic [2:0]         flags;

  // mask = 2^cks - 1, built by shifting zeros into an all-ones word
  assign presc_mask = ~({PRESC_W{1'b1}} << bus.cks);
  assign tick       = bus.en && ((presc & presc_mask) == presc_mask);
  assign flags      = {cmp_q, udf_q, ovf_q};

  always_comb begin
    cnt_nxt = cnt_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    cmp_set = 1'b0;
    if (bus.load) begin
      cnt_nxt = bus.tdr;
    end else if (tick) begin
      if (bus.updown) begin
        if (cnt_q == '1) begin
          cnt_nxt = bus.arld ? bus.tdr : '0;
          ovf_set = 1'b1;
        end else begin
          cnt_nxt = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_nxt = bus.arld ? bus.tdr : '1;
          udf_set = 1'b1;
        end else begin
          cnt_nxt = cnt_q - WIDTH'(1);
        end
      end
      // compare is judged on the value being written, so wraps/reloads count
      cmp_set = (cnt_nxt == bus.cmp);
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      presc <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      cmp_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      presc <= (bus.en && !bus.load) ? presc + PRESC_W'(1) : '0;
      cnt_q <= cnt_nxt;
      ovf_q <= ovf_set | (ovf_q & ~bus.clr_flags[0]);
      udf_q <= udf_set | (udf_q & ~bus.clr_flags[1]);
      cmp_q <= cmp_set | (cmp_q & ~bus.clr_flags[2]);
      irq_q <= |(flags & bus.irq_en);
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.tick     = tick;
  assign bus.ovf_flag = ovf_q;
  assign bus.udf_flag = udf_q;
  assign bus.cmp_flag = cmp_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_timer_counter_ar.sv
// Scoreboard bench for timer_counter_ar: driver models each cycle and queues the
// expected post-edge state; an independent monitor pops and compares.
module tb_timer_counter_ar;
  localparam int W    = 4;
  localparam int CW   = 2;
  localparam int MAXV = (1 << W) - 1;

  logic pclk = 1'b0;
  logic preset = 1'b1;

  timer_counter_ar_if #(.WIDTH(W), .CKS_W(CW)) bus ();

  timer_counter_ar #(.WIDTH(W), .CKS_W(CW)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int cnt;
    bit tick;
    bit ovf;
    bit udf;
    bit cmpf;
    bit irq;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   glitch = 1'b0;

  // reference state: run = consecutive enabled, non-load cycles since last clear
  int m_cnt = 0;
  int m_run = 0;
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;
  bit m_cmp = 1'b0;
  bit m_irq = 1'b0;

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, expv);
    end
  endtask

  task automatic model_cycle();
    int   period;
    bit   tk;
    int   nxt;
    bit   so, su, sc, irq_n;
    exp_t e;
    period = 1 << int'(bus.cks);
    tk     = bus.en && ((m_run % period) == period - 1);
    if (preset) begin
      m_cnt = 0; m_run = 0;
      m_ovf = 0; m_udf = 0; m_cmp = 0; m_irq = 0;
    end else begin
      nxt = m_cnt; so = 0; su = 0; sc = 0;
      irq_n = (m_ovf && bus.irq_en[0]) || (m_udf && bus.irq_en[1]) ||
              (m_cmp && bus.irq_en[2]);
      if (bus.load) begin
        nxt = int'(bus.tdr);
      end else if (tk) begin
        if (bus.updown) begin
          nxt = m_cnt + 1;
          if (nxt > MAXV) begin
            nxt = bus.arld ? int'(bus.tdr) : 0;
            so  = 1;
          end
        end else begin
          nxt = m_cnt - 1;
          if (nxt < 0) begin
            nxt = bus.arld ? int'(bus.tdr) : MAXV;
            su  = 1;
          end
        end
        sc = (nxt == int'(bus.cmp));
      end
      m_run = (bus.en && !bus.load) ? (m_run + 1) % 64 : 0;
      m_ovf = so || (m_ovf && !bus.clr_flags[0]);
      m_udf = su || (m_udf && !bus.clr_flags[1]);
      m_cmp = sc || (m_cmp && !bus.clr_flags[2]);
      m_irq = irq_n;
      m_cnt = nxt;
    end
    e.cnt  = m_cnt;
    e.tick = bus.en && ((m_run % period) == period - 1);
    e.ovf  = m_ovf;
    e.udf  = m_udf;
    e.cmpf = m_cmp;
    e.irq  = m_irq;
    q.push_back(e);
  endtask

  // called at a negedge with inputs already set; returns at the next negedge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      if (glitch) begin
        preset = 1'b1;
        #1;
        preset = 1'b0;
      end
      model_cycle();
      @(negedge pclk);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge pclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("cnt",      int'(bus.cnt),      e.cnt);
        check("tick",     int'(bus.tick),     int'(e.tick));
        check("ovf_flag", int'(bus.ovf_flag), int'(e.ovf));
        check("udf_flag", int'(bus.udf_flag), int'(e.udf));
        check("cmp_flag", int'(bus.cmp_flag), int'(e.cmpf));
        check("irq",      int'(bus.irq),      int'(e.irq));
      end
    end
  end

  initial begin
    bus.en = 0; bus.load = 0; bus.updown = 1; bus.arld = 0; bus.cks = '0;
    bus.tdr = '0; bus.cmp = 4'd9; bus.clr_flags = '0; bus.irq_en = '0;
    @(negedge pclk);
    preset = 1;
    step(2);

    // up-count wrap at cks=0
    preset = 0; bus.irq_en = 3'b001; bus.en = 1;
    step(19);

    // prescaled down-count with auto-reload
    preset = 1; step(1); preset = 0;
    bus.en = 0; bus.tdr = 4'd3; bus.load = 1; step(1); bus.load = 0;
    bus.cks = 2'd2; bus.updown = 0; bus.arld = 1; bus.en = 1;
    step(22);

    // compare match then clear
    preset = 1; step(1); preset = 0;
    bus.cks = 2'd1; bus.updown = 1; bus.arld = 0; bus.cmp = 4'd5;
    bus.irq_en = 3'b100; bus.en = 1;
    step(12);
    bus.en = 0; bus.clr_flags = 3'b100; step(1); bus.clr_flags = '0;
    step(3);

    // set/clear collision on the wrap edge
    preset = 1; step(1); preset = 0;
    bus.cks = '0; bus.cmp = 4'd9; bus.irq_en = 3'b001; bus.en = 1;
    step(15);
    bus.clr_flags = 3'b001; step(1); bus.clr_flags = '0;
    step(2);
    bus.clr_flags = 3'b001; step(1); bus.clr_flags = '0;
    step(2);

    // load beats tick
    preset = 1; step(1); preset = 0;
    step(7);
    bus.tdr = 4'd12; bus.load = 1; step(1); bus.load = 0;
    step(3);

    // reset mid-count, including a pulse that never meets an edge
    preset = 1; step(1); preset = 0;
    bus.cmp = 4'd4; bus.irq_en = 3'b111;
    step(9);
    glitch = 1; step(1); glitch = 0;
    preset = 1; step(3); preset = 0;
    step(6);

    for (int i = 0; i < 1500; i++) begin
      preset        = ($urandom_range(0, 79) == 0);
      bus.en        = ($urandom_range(0, 9) != 0);
      bus.load      = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) bus.updown = 1'($urandom);
      if ($urandom_range(0, 19) == 0) bus.arld   = 1'($urandom);
      if ($urandom_range(0, 24) == 0) bus.cks    = CW'($urandom);
      if ($urandom_range(0, 9) == 0)  bus.tdr    = W'($urandom);
      if ($urandom_range(0, 9) == 0)  bus.cmp    = W'($urandom);
      if ($urandom_range(0, 29) == 0) bus.irq_en = 3'($urandom);
      bus.clr_flags = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      glitch        = ($urandom_range(0, 99) == 0);
      step(1);
    end
    glitch = 0; preset = 0; bus.load = 0; bus.clr_flags = '0;

    repeat (3) @(negedge pclk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
